uart_tx_fifo: RTL

//  Transmit side of the memory-mapped UART in the IO page (gp = 0x400000).

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit half of the memory-mapped UART.
// CPU stores to the UART data word are buffered in a small FIFO and
// serialised as 8N1 frames on uart_tx. uart_busy is polled by putc.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ_HZ = 12000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_wr,
   input  logic [7:0] uart_wdata,
   output logic       uart_busy,
   output logic       uart_full,
   output logic       uart_overflow,
   output logic       uart_tx
);

   localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned BC_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow_q;

   // Serialiser state
   state_t           state;
   logic [BC_W-1:0]  bc;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             tx_q;

   // Decoded control
   logic             push;
   logic             pop;
   logic             tick;
   logic [7:0]       head;

   // Push/pop decisions use the pre-edge count; a pop never frees a slot
   // for a write arriving on the same edge.
   always_comb begin
      push = uart_wr && (count != CNT_FULL);
      tick = (bc == BC_LAST);
      pop  = (count != '0) && ((state == IDLE) || ((state == STOP) && tick));
      head = mem[rd_ptr];
   end

   // FIFO storage, pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[PTR_W'(i)] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= uart_wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (uart_wr && !push) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // 8N1 frame sequencer with registered serial output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         bc      <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               bc   <= '0;
               if (pop) begin
                  shift <= head;
                  state <= START;
                  tx_q  <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  bc      <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx_q    <= shift[0];
               end else begin
                  bc <= bc + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  bc      <= '0;
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     // next bit is presented in the same edge the shift happens
                     tx_q <= shift[1];
                  end
               end else begin
                  bc <= bc + 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  bc <= '0;
                  if (pop) begin
                     shift <= head;
                     state <= START;
                     tx_q  <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx_q  <= 1'b1;
                  end
               end else begin
                  bc <= bc + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   // Status outputs decoded from registers only
   always_comb begin
      uart_tx       = tx_q;
      uart_overflow = overflow_q;
      uart_full     = (count == CNT_FULL);
      uart_busy     = (count != '0) || (state != IDLE);
   end

endmodule
